// File: rtl/ddr_app_arbiter.sv
// Round-robin sharing of one DDR4 app interface between NUM_REQ burst movers,
// with an in-order ID FIFO steering read returns back to the issuing mover.
//
// state   | meaning
// INIT    | waiting for DDR calibration
// ARB     | idle, picking the next requester round-robin
// BURST   | issuing beats of the granted burst
module ddr_app_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 512,
    parameter int LEN_W     = 8,
    parameter int ADDR_STEP = 8,
    parameter int ID_DEPTH  = 32
) (
    input  logic                      core_clk,
    input  logic                      sys_rst_n,
    input  logic                      init_calib_complete,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*DATA_W-1:0] wr_data,
    input  logic [NUM_REQ-1:0]        wr_valid,
    output logic [NUM_REQ-1:0]        wr_ready,
    output logic [DATA_W-1:0]         rd_data,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic                      busy,
    output logic                      err_rd_underflow,
    output logic                      app_en,
    output logic [2:0]                app_cmd,
    output logic [ADDR_W-1:0]         app_addr,
    input  logic                      app_rdy,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    output logic [DATA_W-1:0]         app_wdf_data,
    output logic [DATA_W/8-1:0]       app_wdf_mask,
    input  logic                      app_wdf_rdy,
    input  logic [DATA_W-1:0]         app_rd_data,
    input  logic                      app_rd_data_valid
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(ID_DEPTH);
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_REQ  = IDX_W'(NUM_REQ - 1);

    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_ARB   = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;

    logic [1:0]        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  gnt;
    logic              burst_wr;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  beats_left;

    logic [IDX_W-1:0]  arb_sel;
    logic [IDX_W:0]    arb_idx;
    logic              arb_found;
    logic              in_burst;
    logic              fire;

    logic [IDX_W-1:0]  id_mem [ID_DEPTH];
    logic [PTR_W:0]    id_wr_ptr;
    logic [PTR_W:0]    id_rd_ptr;
    logic              id_empty;
    logic              id_full;
    logic              id_push;
    logic              id_pop;

    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_idx = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (arb_idx >= NUM_REQ_W)
                arb_idx = arb_idx - NUM_REQ_W;
            if (!arb_found && req_valid[arb_idx[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_sel   = arb_idx[IDX_W-1:0];
            end
        end
    end

    assign in_burst = (state == S_BURST);
    assign id_empty = (id_wr_ptr == id_rd_ptr);
    assign id_full  = (id_wr_ptr[PTR_W] != id_rd_ptr[PTR_W]) &&
                      (id_wr_ptr[PTR_W-1:0] == id_rd_ptr[PTR_W-1:0]);
    assign id_pop   = app_rd_data_valid && !id_empty;
    assign id_push  = fire && !burst_wr;

    // A pop in the same cycle frees a slot, so a full FIFO may still accept a read.
    always_comb begin
        req_ready    = '0;
        wr_ready     = '0;
        app_en       = 1'b0;
        app_cmd      = 3'b000;
        app_wdf_data = '0;
        if (state == S_ARB && arb_found)
            req_ready[arb_sel] = 1'b1;
        if (in_burst) begin
            if (burst_wr)
                app_en = wr_valid[gnt] & app_wdf_rdy;
            else begin
                app_en  = !id_full || id_pop;
                app_cmd = 3'b001;
            end
        end
        fire         = app_en & app_rdy;
        app_wdf_wren = fire & burst_wr;
        if (app_wdf_wren) begin
            wr_ready[gnt] = 1'b1;
            app_wdf_data  = wr_data[int'(gnt)*DATA_W +: DATA_W];
        end
    end

    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_mask = '0;
    assign app_addr     = cur_addr;
    assign busy         = in_burst || !id_empty;

    always_ff @(posedge core_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= S_INIT;
            rr_ptr     <= '0;
            gnt        <= '0;
            burst_wr   <= 1'b0;
            cur_addr   <= '0;
            beats_left <= '0;
        end else begin
            case (state)
                S_INIT: if (init_calib_complete) state <= S_ARB;
                S_ARB: begin
                    if (arb_found) begin
                        gnt        <= arb_sel;
                        burst_wr   <= req_wr[arb_sel];
                        cur_addr   <= req_addr[int'(arb_sel)*ADDR_W +: ADDR_W];
                        beats_left <= req_len[int'(arb_sel)*LEN_W +: LEN_W];
                        state      <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (fire) begin
                        if (beats_left == '0) begin
                            state  <= S_ARB;
                            rr_ptr <= (gnt == LAST_REQ) ? '0 : gnt + 1'b1;
                        end else begin
                            beats_left <= beats_left - 1'b1;
                            cur_addr   <= cur_addr + ADDR_W'(ADDR_STEP);
                        end
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    always_ff @(posedge core_clk) begin
        if (id_push)
            id_mem[id_wr_ptr[PTR_W-1:0]] <= gnt;
    end

    always_ff @(posedge core_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            id_wr_ptr        <= '0;
            id_rd_ptr        <= '0;
            rd_valid         <= '0;
            rd_data          <= '0;
            err_rd_underflow <= 1'b0;
        end else begin
            if (id_push)
                id_wr_ptr <= id_wr_ptr + 1'b1;
            if (id_pop)
                id_rd_ptr <= id_rd_ptr + 1'b1;
            rd_valid <= '0;
            if (id_pop) begin
                rd_valid[id_mem[id_rd_ptr[PTR_W-1:0]]] <= 1'b1;
                rd_data <= app_rd_data;
            end
            if (app_rd_data_valid && id_empty)
                err_rd_underflow <= 1'b1;
        end
    end

endmodule
